// File: rtl/z80_interrupt_controller.sv
// rtl/z80_interrupt_controller.sv - Z80 IM2 vectored interrupt controller with mask/pend/mode registers
module z80_interrupt_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_cs_n,
    input  logic       i_rd_n,
    input  logic       i_wr_n,
    input  logic       i_m1_n,
    input  logic       i_iorq_n,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    input  logic [7:0] i_irq,
    output logic       o_int
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_VEC  = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    state_t                         state_q, state_d;
    logic [SYNC_STAGES-1:0][7:0]    sync_q, sync_d;
    logic [7:0]                     s_prev_q, s_prev_d;
    logic [3:0]                     base_q, base_d;
    logic [7:0]                     mask_q, mask_d;
    logic [7:0]                     mode_q, mode_d;
    logic [7:0]                     pend_q, pend_d;
    logic [7:0]                     vec_q, vec_d;
    logic [2:0]                     ack_id_q, ack_id_d;
    logic [2:0]                     last_id_q, last_id_d;
    logic                           spurious_q, spurious_d;
    logic                           int_q, int_d;

    logic [7:0] s;
    logic [7:0] eligible;
    logic [2:0] win_id;
    logic       wr_en;
    logic       ack_start;
    logic       ack_end;
    logic [7:0] clr_wr;
    logic [7:0] clr_ack;
    logic [7:0] set_edge;
    logic [7:0] edge_next;

    assign s         = sync_q[SYNC_STAGES-1];
    assign eligible  = pend_q & mask_q;
    assign wr_en     = ~i_cs_n & ~i_wr_n;
    assign ack_start = (state_q == IDLE) & ~i_m1_n & ~i_iorq_n;
    assign ack_end   = (state_q == ACK) & (i_m1_n | i_iorq_n);

    // Lowest-numbered eligible source wins; 7 stands in when nothing is eligible
    always_comb begin
        win_id = 3'd7;
        for (int n = 7; n >= 0; n--) begin
            if (eligible[n]) begin
                win_id = 3'(n);
            end
        end
    end

    // Next-state for synchronizers, registers, pending bits and the acknowledge FSM
    always_comb begin
        sync_d     = sync_q;
        s_prev_d   = s;
        base_d     = base_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        state_d    = state_q;
        vec_d      = vec_q;
        ack_id_d   = ack_id_q;
        last_id_d  = last_id_q;
        spurious_d = spurious_q;
        int_d      = |eligible;

        sync_d[0] = i_irq;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        if (wr_en) begin
            case (i_addr)
                ADDR_VEC:  base_d = i_data[7:4];
                ADDR_MASK: mask_d = i_data;
                ADDR_MODE: mode_d = i_data;
                default:   ;
            endcase
        end

        // Edge sources: set beats clear when both land on the same cycle
        clr_wr    = (wr_en && i_addr == ADDR_PEND) ? i_data : 8'h00;
        clr_ack   = (ack_end && !spurious_q) ? (8'h01 << ack_id_q) : 8'h00;
        set_edge  = s & ~s_prev_q;
        edge_next = (pend_q & ~(clr_wr | clr_ack)) | set_edge;
        pend_d    = (mode_q & edge_next) | (~mode_q & s);

        case (state_q)
            IDLE: begin
                if (ack_start) begin
                    state_d    = ACK;
                    vec_d      = {base_q, win_id, 1'b0};
                    ack_id_d   = win_id;
                    last_id_d  = win_id;
                    spurious_d = ~|eligible;
                end
            end
            ACK: begin
                if (ack_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            s_prev_q   <= 8'h00;
            base_q     <= 4'h0;
            mask_q     <= 8'h00;
            mode_q     <= 8'h00;
            pend_q     <= 8'h00;
            vec_q      <= 8'h00;
            ack_id_q   <= 3'd0;
            last_id_q  <= 3'd0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            s_prev_q   <= s_prev_d;
            base_q     <= base_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            vec_q      <= vec_d;
            ack_id_q   <= ack_id_d;
            last_id_q  <= last_id_d;
            spurious_q <= spurious_d;
            int_q      <= int_d;
        end
    end

    // Read mux; the frozen vector takes over the bus during acknowledge
    always_comb begin
        o_data = 8'h00;
        if (state_q == ACK) begin
            o_data = vec_q;
        end else begin
            case (i_addr)
                ADDR_VEC:  o_data = {base_q, last_id_q, 1'b0};
                ADDR_MASK: o_data = mask_q;
                ADDR_PEND: o_data = pend_q;
                ADDR_MODE: o_data = mode_q;
                default:   o_data = 8'h00;
            endcase
        end
    end

    assign o_data_oe = (~i_cs_n & ~i_rd_n) | (state_q == ACK);
    assign o_int     = int_q;

endmodule
